adder_arbiter: RTL and testbench

- Shares one W-bit combinational adder between NREQ requesters.
- Round-robin arbitration with a valid/ready handshake on each requester port.
- Drives the shared adder's operand inputs and captures its sum into a single registered response slot, tagged with the requester index.
- Sits between the datapath clients and the adder instance. The adder stays outside this block.

---
 rtl/adder_arbiter_if.sv | 60 ++++++
 rtl/adder_arbiter.sv | 121 ++++++++++++
 tb/tb_adder_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adder_arbiter_if.sv
// Bundle of the requester, shared-adder and response signals of adder_arbiter.
// The slave modport is the arbiter's view; the master modport is the view of
// the surrounding datapath (requesters, response consumer and the adder).
interface adder_arbiter_if #(
  parameter int unsigned W    = 16,
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
);

  // Requester side: one valid/ready pair per requester, operands flattened
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_ready;

  // Shared combinational adder
  logic [W-1:0]      add_a;
  logic [W-1:0]      add_b;
  logic [W-1:0]      add_y;

  // Response slot
  logic              rsp_valid;
  logic [W-1:0]      rsp_data;
  logic [IDW-1:0]    rsp_id;
  logic              rsp_ready;

  // Activity indication
  logic              busy;

  modport slave (
    input  req_valid,
    input  req_a,
    input  req_b,
    output req_ready,
    output add_a,
    output add_b,
    input  add_y,
    output rsp_valid,
    output rsp_data,
    output rsp_id,
    input  rsp_ready,
    output busy
  );

  modport master (
    output req_valid,
    output req_a,
    output req_b,
    input  req_ready,
    input  add_a,
    input  add_b,
    output add_y,
    input  rsp_valid,
    input  rsp_data,
    input  rsp_id,
    output rsp_ready,
    input  busy
  );

endinterface

// File: rtl/adder_arbiter.sv
// adder_arbiter: shares one external W-bit combinational adder among NREQ
// requesters. A round-robin scan starting at rr_ptr picks one valid requester
// whenever the single response slot is free (empty, or being drained in the
// same cycle), routes its operands to the adder and captures the returned sum
// into the registered response slot tagged with the requester index.
module adder_arbiter #(
  parameter int unsigned W    = 16,
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  adder_arbiter_if.slave bus
);

  // Index arithmetic modulo NREQ. Both base and offset are below NREQ, so a
  // single conditional subtraction is enough and non-power-of-two NREQ never
  // yields an index >= NREQ.
  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base,
                                              input int unsigned    off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= NREQ) begin
      sum = sum - NREQ;
    end else begin
      sum = sum;
    end
    return sum[IDW-1:0];
  endfunction

  // Registered state
  logic           rsp_valid_q, rsp_valid_d;
  logic [W-1:0]   rsp_data_q,  rsp_data_d;
  logic [IDW-1:0] rsp_id_q,    rsp_id_d;
  logic [IDW-1:0] rr_ptr_q,    rr_ptr_d;

  // Combinational arbitration results
  logic            slot_free_s;
  logic            grant_found_s;
  logic [IDW-1:0]  grant_idx_s;
  logic [NREQ-1:0] req_ready_s;
  logic [W-1:0]    add_a_s;
  logic [W-1:0]    add_b_s;

  // Round-robin scan from rr_ptr; the first valid requester wins while the slot is free
  always_comb begin
    slot_free_s   = !rsp_valid_q || bus.rsp_ready;
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    if (slot_free_s) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        if (!grant_found_s && bus.req_valid[wrap_add(rr_ptr_q, k)]) begin
          grant_found_s = 1'b1;
          grant_idx_s   = wrap_add(rr_ptr_q, k);
        end else begin
          grant_found_s = grant_found_s;
        end
      end
    end else begin
      grant_found_s = 1'b0;
    end
  end

  // One-hot ready and operand routing for the granted requester; zeros when idle
  always_comb begin
    req_ready_s = '0;
    add_a_s     = '0;
    add_b_s     = '0;
    if (grant_found_s) begin
      req_ready_s[grant_idx_s] = 1'b1;
      add_a_s = bus.req_a[grant_idx_s*W +: W];
      add_b_s = bus.req_b[grant_idx_s*W +: W];
    end else begin
      req_ready_s = '0;
    end
  end

  // Next state of the response slot and the round-robin pointer
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    rr_ptr_d    = rr_ptr_q;
    if (grant_found_s) begin
      // A grant always completes a handshake: the winner is valid by construction
      rsp_valid_d = 1'b1;
      rsp_data_d  = bus.add_y;
      rsp_id_d    = grant_idx_s;
      rr_ptr_d    = wrap_add(grant_idx_s, 32'd1);
    end else if (rsp_valid_q && bus.rsp_ready) begin
      // Drain with nothing to refill: data and id keep their last values
      rsp_valid_d = 1'b0;
    end else begin
      rsp_valid_d = rsp_valid_q;
    end
  end

  // Response slot and pointer registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rr_ptr_q    <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign bus.req_ready = req_ready_s;
  assign bus.add_a     = add_a_s;
  assign bus.add_b     = add_b_s;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.busy      = rsp_valid_q || (|bus.req_valid);

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter. The shared adder is modelled here as
// a plain '+'. A transaction-level model (slot contents, next-priority index)
// predicts grants and responses from the rules: scan from the priority index
// modulo NREQ, accept only when the slot is free, result = (a+b) mod 2**W.
module tb_adder_arbiter;

  localparam int W    = 16;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  adder_arbiter_if #(.W(W), .NREQ(NREQ), .IDW(IDW)) bus ();

  // External shared adder
  assign bus.add_y = bus.add_a + bus.add_b;

  adder_arbiter #(.W(W), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic        m_valid;
  logic [15:0] m_data;
  int          m_id;
  int          m_ptr;
  logic [15:0] ra [NREQ];
  logic [15:0] rb [NREQ];

  function automatic int model_grant();
    if (m_valid && !bus.rsp_ready) return -1;
    for (int k = 0; k < NREQ; k++) begin
      int idx = (m_ptr + k) % NREQ;
      if (bus.req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [15:0] ref_sum(int i);
    logic [16:0] s;
    s = {1'b0, ra[i]} + {1'b0, rb[i]};
    return s[15:0];
  endfunction

  function automatic logic [3:0] onehot(int g);
    logic [3:0] r;
    r = 4'b0000;
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic set_op(int i, logic [15:0] a, logic [15:0] b);
    ra[i] = a;
    rb[i] = b;
    bus.req_a[i*W +: W] = a;
    bus.req_b[i*W +: W] = b;
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = 16'h0000;
    m_id    = 0;
    m_ptr   = 0;
  endtask

  // Advance the model by one accepted edge, then step the clock
  task automatic model_clock();
    int g;
    g = model_grant();
    if (g >= 0) begin
      m_valid = 1'b1;
      m_data  = ref_sum(g);
      m_id    = g;
      m_ptr   = (g + 1) % NREQ;
    end else if (m_valid && bus.rsp_ready) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req_valid = 4'b0000;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) set_op(i, 16'h0000, 16'h0000);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = 4'b0000;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) set_op(i, 16'h0000, 16'h0000);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.rsp_valid); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (bus.rsp_data !== 16'h0000) begin bad++; $display("FAIL idle_data got=%h exp=0000", bus.rsp_data); end
    total++;
    if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL idle_ready got=%b exp=0000", bus.req_ready); end
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b exp=0", bus.busy); end
    total++;
    if ({bus.add_a, bus.add_b} !== 32'h0) begin bad++; $display("FAIL idle_add got=%h/%h exp=0/0", bus.add_a, bus.add_b); end
    total++;
    if (bus.rsp_id !== 2'd0) begin bad++; $display("FAIL idle_id got=%0d exp=0", bus.rsp_id); end
  endtask

  task automatic test_single();
    set_op(0, 16'h1234, 16'h0101);
    bus.req_valid = 4'b0001;
    bus.rsp_ready = 1'b1;
    #1;
    total++;
    if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL single_ready got=%b exp=0001", bus.req_ready); end
    total++;
    if (bus.add_a !== 16'h1234 || bus.add_b !== 16'h0101) begin bad++; $display("FAIL single_ops got=%h/%h exp=1234/0101", bus.add_a, bus.add_b); end
    model_clock();
    bus.req_valid = 4'b0000;
    total++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 16'h1335 || bus.rsp_id !== 2'd0) begin
      bad++; $display("FAIL single_rsp got=%b/%h/%0d exp=1/1335/0", bus.rsp_valid, bus.rsp_data, bus.rsp_id);
    end
    model_clock();
    total++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== 16'h1335) begin
      bad++; $display("FAIL drain_hold got=%b/%h exp=0/1335", bus.rsp_valid, bus.rsp_data);
    end
  endtask

  task automatic test_wrap();
    set_op(2, 16'hFFFF, 16'h0002);
    bus.req_valid = 4'b0100;
    bus.rsp_ready = 1'b1;
    model_clock();
    bus.req_valid = 4'b0000;
    total++;
    if (bus.rsp_data !== 16'h0001 || bus.rsp_id !== 2'd2) begin
      bad++; $display("FAIL wrap got=%h/%0d exp=0001/2", bus.rsp_data, bus.rsp_id);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < NREQ; i++) set_op(i, 16'(i), 16'd10);
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      model_clock();
      total++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== IDW'(c % 4) || bus.rsp_data !== 16'(10 + c % 4)) begin
        bad++; $display("FAIL rr_step%0d got=%b/%0d/%0d exp=1/%0d/%0d", c, bus.rsp_valid, bus.rsp_id, bus.rsp_data, c % 4, 10 + c % 4);
      end
    end
  endtask

  task automatic test_backpressure();
    // Slot holds id 0 / data 10; next priority is index 1
    bus.req_valid = 4'b0110;
    bus.rsp_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      total++;
      if (bus.req_ready !== 4'b0000 || bus.rsp_valid !== 1'b1 || bus.rsp_data !== 16'd10) begin
        bad++; $display("FAIL bp_hold%0d got=%b/%b/%0d exp=0000/1/10", c, bus.req_ready, bus.rsp_valid, bus.rsp_data);
      end
      model_clock();
    end
    bus.rsp_ready = 1'b1;
    #1;
    total++;
    if (bus.req_ready !== 4'b0010 || bus.add_a !== 16'd1) begin
      bad++; $display("FAIL bp_release got=%b/%h exp=0010/0001", bus.req_ready, bus.add_a);
    end
    model_clock();
    bus.req_valid[1] = 1'b0;
    total++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 || bus.rsp_data !== 16'd11) begin
      bad++; $display("FAIL bp_first got=%b/%0d/%0d exp=1/1/11", bus.rsp_valid, bus.rsp_id, bus.rsp_data);
    end
    model_clock();
    bus.req_valid = 4'b0000;
    total++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd2 || bus.rsp_data !== 16'd12) begin
      bad++; $display("FAIL bp_second got=%b/%0d/%0d exp=1/2/12", bus.rsp_valid, bus.rsp_id, bus.rsp_data);
    end
  endtask

  task automatic test_reset_mid();
    set_op(3, 16'h0F00, 16'h00F0);
    bus.req_valid = 4'b1000;
    bus.rsp_ready = 1'b1;
    model_clock();
    bus.req_valid = 4'b0000;
    bus.rsp_ready = 1'b0;
    total++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 16'h0FF0) begin
      bad++; $display("FAIL mid_pre got=%b/%h exp=1/0ff0", bus.rsp_valid, bus.rsp_data);
    end
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    total++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== 16'h0000) begin
      bad++; $display("FAIL mid_async got=%b/%h exp=0/0000", bus.rsp_valid, bus.rsp_data);
    end
    repeat (2) @(posedge clk);
    #1;
    set_op(1, 16'h0003, 16'h0004);
    set_op(3, 16'h0005, 16'h0006);
    bus.req_valid = 4'b1010;
    bus.rsp_ready = 1'b1;
    rst_n = 1'b1;
    #1;
    total++;
    if (bus.req_ready !== 4'b0010) begin bad++; $display("FAIL mid_first_grant got=%b exp=0010", bus.req_ready); end
    model_clock();
    bus.req_valid = 4'b0000;
    total++;
    if (bus.rsp_id !== 2'd1 || bus.rsp_data !== 16'd7) begin
      bad++; $display("FAIL mid_first_rsp got=%0d/%0d exp=1/7", bus.rsp_id, bus.rsp_data);
    end
  endtask

  task automatic test_random();
    logic       pend [NREQ];
    int         wcnt [NREQ];
    int         g;
    logic [3:0] exp_rdy;
    for (int i = 0; i < NREQ; i++) begin pend[i] = 1'b0; wcnt[i] = 0; end
    bus.req_valid = 4'b0000;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          set_op(i, 16'($urandom), 16'($urandom));
          bus.req_valid[i] = 1'b1;
        end
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      g = model_grant();
      exp_rdy = onehot(g);
      total++;
      if (bus.req_ready !== exp_rdy) begin bad++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, bus.req_ready, exp_rdy); end
      total++;
      if (g >= 0) begin
        if (bus.add_a !== ra[g] || bus.add_b !== rb[g]) begin
          bad++; $display("FAIL rnd_ops c=%0d got=%h/%h exp=%h/%h", c, bus.add_a, bus.add_b, ra[g], rb[g]);
        end
      end else if ({bus.add_a, bus.add_b} !== 32'h0) begin
        bad++; $display("FAIL rnd_ops_idle c=%0d got=%h/%h exp=0/0", c, bus.add_a, bus.add_b);
      end
      total++;
      if (bus.busy !== (m_valid || (|bus.req_valid))) begin
        bad++; $display("FAIL rnd_busy c=%0d got=%b exp=%b", c, bus.busy, m_valid || (|bus.req_valid));
      end
      if (g >= 0) begin
        total++;
        if (wcnt[g] > NREQ - 1) begin bad++; $display("FAIL rnd_fair c=%0d req=%0d waited=%0d max=%0d", c, g, wcnt[g], NREQ - 1); end
        for (int i = 0; i < NREQ; i++) if (i != g && pend[i]) wcnt[i]++;
        wcnt[g] = 0;
        pend[g] = 1'b0;
      end
      model_clock();
      if (g >= 0) bus.req_valid[g] = 1'b0;
      total++;
      if (bus.rsp_valid !== m_valid || (m_valid && (bus.rsp_data !== m_data || bus.rsp_id !== IDW'(m_id)))) begin
        bad++; $display("FAIL rnd_rsp c=%0d got=%b/%h/%0d exp=%b/%h/%0d", c, bus.rsp_valid, bus.rsp_data, bus.rsp_id, m_valid, m_data, m_id);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
